fetch_queue_nw: RTL

//  N-wide instruction fetch queue between the bench/instruction source and the OoO core decoder.

---
 rtl/fetch_queue_nw.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fetch_queue_nw.sv
// N-wide fetch queue feeding the decoder; optional FETCH_QUEUE_STATS_EN adds stall/redirect counters.
// Latency: an enqueued entry is visible on the outputs one cycle after its enqueue edge (no bypass).
// Backpressure: enq_ready drops when fewer than ISSUE_WIDTH slots are free; ROB_full holds the outputs.
module fetch_queue_nw #(
    parameter int INSTR_WIDTH = 32,
    parameter int PC_WIDTH    = 32,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ISSUE_WIDTH-1:0]             enq_valid,
    input  logic [ISSUE_WIDTH*PC_WIDTH-1:0]    enq_PC,
    input  logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] enq_instr,
    output logic                               enq_ready,
    input  logic                               ROB_full,
    input  logic                               flush_en,
    input  logic [PC_WIDTH-1:0]                flush_PC,
    input  logic                               branch_en,
    input  logic [PC_WIDTH-1:0]                branch_PC,
    input  logic                               jump_en,
    input  logic [PC_WIDTH-1:0]                jump_PC,
    output logic [ISSUE_WIDTH-1:0]             ins_valid,
    output logic [ISSUE_WIDTH*PC_WIDTH-1:0]    PC_out,
    output logic [ISSUE_WIDTH*INSTR_WIDTH-1:0] instr_out,
    output logic                               redirect_en,
    output logic [PC_WIDTH-1:0]                redirect_PC,
    output logic [$clog2(DEPTH+1)-1:0]         count
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]                        stall_cycles,
    output logic [15:0]                        redirect_count
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] enq_cnt;
    logic [CW-1:0] deq_cnt;
    logic [CW-1:0] enq_take;
    logic [CW-1:0] deq_take;
    logic          redirect;
    logic          run;

    // Only the contiguous run of valid lanes starting at lane 0 is accepted.
    always_comb begin
        enq_cnt = '0;
        run     = 1'b1;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (run && enq_valid[i]) enq_cnt = enq_cnt + CW'(1);
            else                     run     = 1'b0;
        end
    end

    assign redirect  = flush_en | branch_en | jump_en;
    assign enq_ready = (count <= CW'(DEPTH - ISSUE_WIDTH));
    assign deq_cnt   = (count < CW'(ISSUE_WIDTH)) ? count : CW'(ISSUE_WIDTH);
    assign enq_take  = enq_ready ? enq_cnt : '0;
    assign deq_take  = ROB_full ? '0 : deq_cnt;

    always_comb begin
        ins_valid = '0;
        PC_out    = '0;
        instr_out = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (CW'(i) < count) begin
                ins_valid[i]                              = 1'b1;
                PC_out[i*PC_WIDTH +: PC_WIDTH]            = mem[head + PW'(i)].pc;
                instr_out[i*INSTR_WIDTH +: INSTR_WIDTH]   = mem[head + PW'(i)].instr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            redirect_en <= 1'b0;
            redirect_PC <= '0;
        end else begin
            redirect_en <= redirect;
            if (redirect) begin
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                redirect_PC <= flush_en ? flush_PC : (branch_en ? branch_PC : jump_PC);
            end else begin
                tail  <= tail + PW'(enq_take);
                head  <= head + PW'(deq_take);
                count <= count + enq_take - deq_take;
            end
        end
    end

    // Storage carries no reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (rst && !redirect && enq_ready) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (CW'(i) < enq_cnt) begin
                    mem[tail + PW'(i)] <= '{pc:    enq_PC[i*PC_WIDTH +: PC_WIDTH],
                                            instr: enq_instr[i*INSTR_WIDTH +: INSTR_WIDTH]};
                end
            end
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles   <= '0;
            redirect_count <= '0;
        end else begin
            if (count != '0 && ROB_full && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (redirect && redirect_count != '1)              redirect_count <= redirect_count + 16'd1;
        end
    end
`endif
endmodule
